itof_pipe: RTL

// - Converts a 32-bit two's-complement integer to an IEEE-754 single-precision float (inverse of the FPU ftoi path).
// - 3-stage pipeline with valid/ready handshake on both sides; sits in the FPU beside the float->int unit and serves the fcvt.s.w path.
// - Output is never denormal, Inf or NaN; the result is exact or rounded per CONFIGURATION.

---
 rtl/itof_pipe_if.sv | 20 ++
 rtl/itof_pipe.sv | 121 ++++++++++++
 2 files changed

// File: rtl/itof_pipe_if.sv
// Handshake/data bundle for the int->float converter.
// slave: the converter side; master: the producer/consumer side.
interface itof_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, y
  );

  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, y
  );
endinterface

// File: rtl/itof_pipe.sv
// itof_pipe: signed 32-bit integer -> IEEE-754 single, 3-stage pipeline.
//   stage 1: sign / magnitude / zero flag
//   stage 2: leading-zero count and normalising shift
//   stage 3: exponent, rounding, packing into the registered output y
// Build option: define ITOF_ROUND_EN for round-to-nearest-even;
// otherwise the mantissa is truncated toward zero.
module itof_pipe (
  input  logic        clk,
  input  logic        rst,
  itof_pipe_if.slave  bus
);

  // Truncating builds never look below n[8], so those bits are not kept.
`ifdef ITOF_ROUND_EN
  localparam int unsigned NLSB = 0;
`else
  localparam int unsigned NLSB = 8;
`endif

  logic        advance;

  // stage 1 registers
  logic        v1, s1, z1;
  logic [31:0] a1;
  logic [31:0] a_d;

  // stage 2 registers
  logic        v2, s2, z2;
  logic [4:0]  l2;
  logic [30:NLSB] n2;
  logic [4:0]  l_d;
  logic [31:0] n_d;
  logic        found;

  // stage 3 (output) registers
  logic        ov_q;
  logic [31:0] y_q;
  logic [31:0] y_d;
  logic [7:0]  e_base, e_r;
  logic [22:0] mant_r;

  // Whole pipe moves together; it only stalls when a result is waiting.
  assign advance      = !ov_q | bus.out_ready;
  assign bus.in_ready = advance;
  assign bus.out_valid = ov_q;
  assign bus.y         = y_q;

  // Magnitude of the operand; 0x80000000 maps onto itself as unsigned.
  always_comb begin
    a_d = bus.x[31] ? (~bus.x + 32'd1) : bus.x;
  end

  // Stage 1 register: sign, magnitude, zero flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
    end else if (advance) begin
      v1 <= bus.in_valid;
      s1 <= bus.x[31];
      z1 <= (bus.x == '0);
      a1 <= a_d;
    end
  end

  // Leading-zero count of the magnitude and normalising left shift.
  always_comb begin
    l_d   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (!found && a1[31 - i]) begin
        l_d   = i[4:0];
        found = 1'b1;
      end
    end
    n_d = a1 << l_d;
  end

  // Stage 2 register: normalised significand and shift amount.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
    end else if (advance) begin
      v2 <= v1;
      s2 <= s1;
      z2 <= z1;
      l2 <= l_d;
      n2 <= n_d[30:NLSB];
    end
  end

  // Exponent, optional rounding with carry into the exponent, packing.
`ifdef ITOF_ROUND_EN
  logic        inc;
  logic [23:0] msum;
`endif
  always_comb begin
    e_base = 8'd158 - {3'b000, l2};
`ifdef ITOF_ROUND_EN
    inc    = n2[7] & ((|n2[6:0]) | n2[8]);
    msum   = {1'b0, n2[30:8]} + {23'd0, inc};
    mant_r = msum[22:0];
    e_r    = e_base + {7'd0, msum[23]};
`else
    mant_r = n2[30:8];
    e_r    = e_base;
`endif
    y_d = z2 ? '0 : {s2, e_r, mant_r};
  end

  // Stage 3 register: the visible result, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      ov_q <= 1'b0;
      y_q  <= '0;
    end else if (advance) begin
      ov_q <= v2;
      y_q  <= y_d;
    end
  end

endmodule
